vram_responder: RTL and testbench

VRAM_RESPONDER -- requirements
Module: vram_responder

---
 rtl/vram_responder_if.sv | 26 ++
 rtl/vram_responder.sv | 124 ++++++++++++
 tb/tb_vram_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/vram_responder_if.sv
// Bus between chroni, the VRAM responder and the SDRAM word-read bridge.
// The responder uses the slave view; the requester/bridge side uses master.
interface vram_responder_if;
  logic        chroni_clk;
  logic        chroni_rd_req;
  logic [7:0]  chroni_page;
  logic [13:0] chroni_addr;
  logic        chroni_rd_ack;
  logic [7:0]  chroni_data;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_rd_ack;
  logic [15:0] mem_rd_data;

  modport slave (
    input  chroni_clk, chroni_rd_req, chroni_page, chroni_addr,
    input  mem_rd_ack, mem_rd_data,
    output chroni_rd_ack, chroni_data, mem_rd_req, mem_addr
  );

  modport master (
    output chroni_clk, chroni_rd_req, chroni_page, chroni_addr,
    output mem_rd_ack, mem_rd_data,
    input  chroni_rd_ack, chroni_data, mem_rd_req, mem_addr
  );
endinterface

// File: rtl/vram_responder.sv
// Serves chroni byte reads from SDRAM 16-bit words through a one-word buffer,
// paced by rising edges of chroni's pixel clock sampled in the CLK_200 domain.
module vram_responder #(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] ERR_DATA       = 8'hFF
) (
  input  logic               CLK_200,
  input  logic               reset_n,
  vram_responder_if.slave    bus,
  input  logic               cache_inv,
  output logic [7:0]         err_count,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  // Handshakes: chroni holds chroni_rd_req as a level and is sampled only on a
  // chroni_clk rising edge; chroni_rd_ack rises from HOLD and falls on the next
  // IDLE start. Memory side: mem_rd_req holds with a stable mem_addr until a
  // 0->1 edge of mem_rd_ack or the timeout, whichever comes first.

  logic [1:0]  state;
  logic        sync1, sync2, sync2_q;
  logic        start;
  logic [16:0] byte_addr;
  logic [16:0] req_addr;
  logic        hit;
  logic [15:0] buf_data;
  logic [15:0] buf_tag;
  logic        buf_valid;
  logic        ack_q;
  logic        ack_edge;
  logic [7:0]  tmo_cnt;
  logic        resp_err;

  assign start     = sync2 & ~sync2_q;
  assign req_addr  = {bus.chroni_page, 9'b0} + {3'b0, bus.chroni_addr};
  assign hit       = buf_valid && (buf_tag == req_addr[16:1]);
  assign ack_edge  = bus.mem_rd_ack & ~ack_q;
  assign state_dbg = state;

  always_ff @(posedge CLK_200) begin
    if (!reset_n) begin
      state             <= IDLE;
      sync1             <= 1'b0;
      sync2             <= 1'b0;
      sync2_q           <= 1'b0;
      byte_addr         <= '0;
      buf_data          <= '0;
      buf_tag           <= '0;
      buf_valid         <= 1'b0;
      ack_q             <= 1'b0;
      tmo_cnt           <= '0;
      resp_err          <= 1'b0;
      err_count         <= '0;
      bus.chroni_rd_ack <= 1'b0;
      bus.chroni_data   <= '0;
      bus.mem_rd_req    <= 1'b0;
      bus.mem_addr      <= '0;
    end else begin
      sync1   <= bus.chroni_clk;
      sync2   <= sync1;
      sync2_q <= sync2;
      ack_q   <= bus.mem_rd_ack;

      case (state)
        IDLE: begin
          if (start) begin
            bus.chroni_rd_ack <= 1'b0;
            if (bus.chroni_rd_req) begin
              byte_addr <= req_addr;
              resp_err  <= 1'b0;
              if (hit) begin
                state <= HOLD;
              end else begin
                state          <= FETCH;
                bus.mem_rd_req <= 1'b1;
                bus.mem_addr   <= req_addr[16:1];
                tmo_cnt        <= '0;
              end
            end
          end
        end

        FETCH: begin
          if (ack_edge) begin
            buf_data       <= bus.mem_rd_data;
            buf_tag        <= byte_addr[16:1];
            buf_valid      <= 1'b1;
            bus.mem_rd_req <= 1'b0;
            state          <= HOLD;
          end else if (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            // Abort leaves the buffer untouched; the response becomes ERR_DATA.
            bus.mem_rd_req <= 1'b0;
            resp_err       <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state          <= HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        HOLD: begin
          if (start) begin
            if (resp_err)          bus.chroni_data <= ERR_DATA;
            else if (byte_addr[0]) bus.chroni_data <= buf_data[15:8];
            else                   bus.chroni_data <= buf_data[7:0];
            bus.chroni_rd_ack <= 1'b1;
            state             <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Invalidation wins over a same-cycle fill; buf_data itself is kept so a
      // response already committed to this word still returns it.
      if (cache_inv) buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_responder.sv
// Directed bench for vram_responder: vector table for plain reads plus
// hand-written sequences for timeout, stale ack, invalidation and reset.
module tb_vram_responder;

  logic       CLK_200 = 1'b0;
  logic       reset_n;
  logic       cache_inv, cache_inv2;
  logic [7:0] err_count, err_count2;
  logic [1:0] state_dbg, state_dbg2;

  int checks = 0;
  int errors = 0;

  vram_responder_if bus ();
  vram_responder_if bus2 ();

  vram_responder dut (
    .CLK_200   (CLK_200),
    .reset_n   (reset_n),
    .bus       (bus),
    .cache_inv (cache_inv),
    .err_count (err_count),
    .state_dbg (state_dbg)
  );

  // Short timeout instance so err_count saturation is reachable quickly.
  vram_responder #(.TIMEOUT_CYCLES(3)) dut_sat (
    .CLK_200   (CLK_200),
    .reset_n   (reset_n),
    .bus       (bus2),
    .cache_inv (cache_inv2),
    .err_count (err_count2),
    .state_dbg (state_dbg2)
  );

  always #5 CLK_200 = ~CLK_200;

  typedef struct {
    logic [7:0]  page;
    logic [13:0] addr;
    bit          inv;
    bit          exp_fetch;
    int          delay;
    logic [15:0] mdata;
    logic [15:0] exp_maddr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chroni_tick(input bit sat);
    @(negedge CLK_200);
    if (sat) bus2.chroni_clk = 1'b1; else bus.chroni_clk = 1'b1;
    repeat (4) @(negedge CLK_200);
    if (sat) bus2.chroni_clk = 1'b0; else bus.chroni_clk = 1'b0;
    repeat (4) @(negedge CLK_200);
  endtask

  task automatic request(input logic [7:0] page, input logic [13:0] addr);
    bus.chroni_rd_req = 1'b1;
    bus.chroni_page   = page;
    bus.chroni_addr   = addr;
    chroni_tick(1'b0);
  endtask

  task automatic mem_pulse(input logic [15:0] data, input bit inv);
    @(negedge CLK_200);
    bus.mem_rd_data = data;
    bus.mem_rd_ack  = 1'b1;
    cache_inv       = inv;
    @(negedge CLK_200);
    bus.mem_rd_ack  = 1'b0;
    cache_inv       = 1'b0;
  endtask

  task automatic respond_check(input string name, input logic [7:0] exp);
    chroni_tick(1'b0);
    check({name, "_ack"}, 32'(bus.chroni_rd_ack), 32'd1);
    check({name, "_data"}, 32'(bus.chroni_data), 32'(exp));
  endtask

  initial begin
    int cnt;

    vecs[0] = '{8'h01, 14'h0003, 1'b0, 1'b1, 10, 16'hBEEF, 16'h0101, 8'hBE};
    vecs[1] = '{8'h01, 14'h0002, 1'b0, 1'b0, 0,  16'h0000, 16'h0000, 8'hEF};
    vecs[2] = '{8'h01, 14'h0002, 1'b1, 1'b1, 3,  16'h1234, 16'h0101, 8'h34};
    vecs[3] = '{8'hFF, 14'h3FFF, 1'b0, 1'b1, 2,  16'hA55A, 16'h1EFF, 8'hA5};
    vecs[4] = '{8'hFF, 14'h3FFE, 1'b0, 1'b0, 0,  16'h0000, 16'h0000, 8'h5A};
    vecs[5] = '{8'h00, 14'h0000, 1'b0, 1'b1, 1,  16'h00C3, 16'h0000, 8'hC3};

    reset_n = 1'b0;
    cache_inv = 1'b0;  cache_inv2 = 1'b0;
    bus.chroni_clk = 1'b0;  bus.chroni_rd_req = 1'b0;
    bus.chroni_page = '0;   bus.chroni_addr = '0;
    bus.mem_rd_ack = 1'b0;  bus.mem_rd_data = '0;
    bus2.chroni_clk = 1'b0; bus2.chroni_rd_req = 1'b0;
    bus2.chroni_page = '0;  bus2.chroni_addr = '0;
    bus2.mem_rd_ack = 1'b0; bus2.mem_rd_data = '0;
    repeat (3) @(negedge CLK_200);

    check("rst_ack",   32'(bus.chroni_rd_ack), 32'd0);
    check("rst_data",  32'(bus.chroni_data),   32'd0);
    check("rst_req",   32'(bus.mem_rd_req),    32'd0);
    check("rst_maddr", 32'(bus.mem_addr),      32'd0);
    check("rst_err",   32'(err_count),         32'd0);
    check("rst_state", 32'(state_dbg),         32'd0);
    reset_n = 1'b1;
    @(negedge CLK_200);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].inv) begin
        @(negedge CLK_200); cache_inv = 1'b1;
        @(negedge CLK_200); cache_inv = 1'b0;
      end
      request(vecs[i].page, vecs[i].addr);
      check($sformatf("v%0d_ackfall", i), 32'(bus.chroni_rd_ack), 32'd0);
      check($sformatf("v%0d_fetch", i), 32'(bus.mem_rd_req), 32'(vecs[i].exp_fetch));
      if (vecs[i].exp_fetch) begin
        check($sformatf("v%0d_maddr", i), 32'(bus.mem_addr), 32'(vecs[i].exp_maddr));
        repeat (vecs[i].delay) @(negedge CLK_200);
        mem_pulse(vecs[i].mdata, 1'b0);
        check($sformatf("v%0d_reqdrop", i), 32'(bus.mem_rd_req), 32'd0);
      end
      respond_check($sformatf("v%0d", i), vecs[i].exp_data);
    end

    // Timeout with ack held low: mem_rd_req must be high for exactly 255 cycles.
    bus.chroni_rd_req = 1'b1; bus.chroni_page = 8'h02; bus.chroni_addr = 14'h0000;
    @(negedge CLK_200);
    bus.chroni_clk = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_200);
      if (bus.mem_rd_req) cnt++;
      else if (cnt > 0) break;
    end
    check("tmo_cycles", 32'(cnt), 32'd255);
    bus.chroni_clk = 1'b0;
    repeat (4) @(negedge CLK_200);
    respond_check("tmo", 8'hFF);
    check("tmo_err", 32'(err_count), 32'd1);
    // The abort must not have disturbed the buffered word 0 (16'h00C3).
    request(8'h00, 14'h0001);
    check("tmo_bufhit", 32'(bus.mem_rd_req), 32'd0);
    respond_check("tmo_buf", 8'h00);

    // Stale ack: high from before the request, completion only on a new rise.
    bus.mem_rd_ack = 1'b1;
    request(8'h03, 14'h0000);
    check("stale_req", 32'(bus.mem_rd_req), 32'd1);
    repeat (20) @(negedge CLK_200);
    check("stale_hold", 32'(bus.mem_rd_req), 32'd1);
    bus.mem_rd_ack = 1'b0;
    repeat (2) @(negedge CLK_200);
    bus.mem_rd_data = 16'h7766;
    bus.mem_rd_ack  = 1'b1;
    @(negedge CLK_200);
    check("stale_done", 32'(bus.mem_rd_req), 32'd0);
    respond_check("stale", 8'h66);
    bus.mem_rd_ack = 1'b0;

    // cache_inv coincident with the ack: data is used, buffer left invalid.
    request(8'h04, 14'h0001);
    check("invack_req", 32'(bus.mem_rd_req), 32'd1);
    mem_pulse(16'h9988, 1'b1);
    respond_check("invack", 8'h99);
    request(8'h04, 14'h0000);
    check("invack_refetch", 32'(bus.mem_rd_req), 32'd1);
    mem_pulse(16'h1111, 1'b0);
    respond_check("invack_new", 8'h11);

    // cache_inv while a hit waits in HOLD: buffered byte is still returned.
    request(8'h04, 14'h0001);
    check("invhold_hit", 32'(bus.mem_rd_req), 32'd0);
    @(negedge CLK_200); cache_inv = 1'b1;
    @(negedge CLK_200); cache_inv = 1'b0;
    respond_check("invhold", 8'h11);
    request(8'h04, 14'h0000);
    check("invhold_refetch", 32'(bus.mem_rd_req), 32'd1);
    mem_pulse(16'h2222, 1'b0);
    respond_check("invhold_new", 8'h22);

    // Start with no request: ack drops, nothing else happens.
    bus.chroni_rd_req = 1'b0;
    chroni_tick(1'b0);
    check("noreq_ack",   32'(bus.chroni_rd_ack), 32'd0);
    check("noreq_req",   32'(bus.mem_rd_req),    32'd0);
    check("noreq_state", 32'(state_dbg),         32'd0);

    // Reset while FETCH is outstanding, then a late ack.
    request(8'h05, 14'h0000);
    check("rstf_req", 32'(bus.mem_rd_req), 32'd1);
    bus.chroni_rd_req = 1'b0;
    reset_n = 1'b0;
    @(negedge CLK_200);
    check("rstf_req0",  32'(bus.mem_rd_req),    32'd0);
    check("rstf_maddr", 32'(bus.mem_addr),      32'd0);
    check("rstf_ack",   32'(bus.chroni_rd_ack), 32'd0);
    check("rstf_data",  32'(bus.chroni_data),   32'd0);
    check("rstf_err",   32'(err_count),         32'd0);
    check("rstf_state", 32'(state_dbg),         32'd0);
    reset_n = 1'b1;
    mem_pulse(16'h5555, 1'b0);
    chroni_tick(1'b0);
    check("late_ack",   32'(bus.chroni_rd_ack), 32'd0);
    check("late_req",   32'(bus.mem_rd_req),    32'd0);
    check("late_state", 32'(state_dbg),         32'd0);

    // err_count saturation on the short-timeout instance.
    bus2.chroni_rd_req = 1'b1;
    for (int i = 0; i < 256; i++) begin
      chroni_tick(1'b1);
      chroni_tick(1'b1);
      if (i == 0) begin
        check("sat_first_data", 32'(bus2.chroni_data), 32'hFF);
        check("sat_first_cnt",  32'(err_count2),       32'd1);
      end
      if (i == 254) check("sat_255", 32'(err_count2), 32'd255);
    end
    check("sat_256", 32'(err_count2), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
